// File: rtl/detour_sign_n.sv
`default_nettype none
// detour_sign_n: sequential detour-arrow lamp chaser with left/right fill and hazard flash.
// Rev 1.0 - initial release.
module detour_sign_n #(
  parameter int NUM_LAMPS   = 4,
  parameter int STEP_CYCLES = 1,
  localparam int SW = $clog2(NUM_LAMPS + 1),
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 En,
  input  logic                 L_Rbar,
  input  logic                 Hazard,
  output logic [NUM_LAMPS-1:0] Lamps,
  output logic [SW-1:0]        Step,
  output logic                 q_I,
  output logic                 q_L,
  output logic                 q_R,
  output logic                 q_F,
  output logic                 Done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2,
    ST_FLASH = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          step_q, step_d;
  logic [NUM_LAMPS-1:0]   lamps_q, lamps_d;
  logic                   done_q, done_d;
  logic                   boundary;
  logic [CW-1:0]          cnt_nxt;

  // Lamp pattern for a given lit count; LEFT fills from the high end.
  function automatic logic [NUM_LAMPS-1:0] fill(input logic left, input logic [SW-1:0] n);
    logic [NUM_LAMPS-1:0] f;
    for (int k = 0; k < NUM_LAMPS; k++) begin
      if (left) f[k] = (k >= NUM_LAMPS - int'(n));
      else      f[k] = (k < int'(n));
    end
    return f;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    lamps_d  = lamps_q;
    done_d   = 1'b0;
    boundary = (cnt_q == CW'(STEP_CYCLES - 1));
    cnt_nxt  = boundary ? '0 : cnt_q + 1'b1;

    if (Hazard) begin
      if (state_q != ST_FLASH) begin
        state_d = ST_FLASH;
        lamps_d = '1;
        cnt_d   = '0;
        step_d  = '0;
      end else begin
        cnt_d = cnt_nxt;
        if (boundary) lamps_d = ~lamps_q;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          lamps_d = '0;
          step_d  = '0;
          if (En) begin
            cnt_d = cnt_nxt;
            if (boundary) begin
              state_d = L_Rbar ? ST_LEFT : ST_RIGHT;
              step_d  = SW'(1);
              lamps_d = fill(L_Rbar, SW'(1));
            end
          end else begin
            cnt_d = '0;
          end
        end
        ST_LEFT, ST_RIGHT: begin
          // En is deliberately ignored here so a started chase always completes.
          cnt_d = cnt_nxt;
          if (boundary) begin
            if (step_q == SW'(NUM_LAMPS)) begin
              state_d = ST_IDLE;
              step_d  = '0;
              lamps_d = '0;
              done_d  = 1'b1;
            end else begin
              step_d  = step_q + 1'b1;
              lamps_d = fill(state_q == ST_LEFT, step_q + 1'b1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          lamps_d = '0;
          cnt_d   = '0;
          step_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      lamps_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      lamps_q <= lamps_d;
      done_q  <= done_d;
    end
  end

  assign Lamps = lamps_q;
  assign Step  = step_q;
  assign Done  = done_q;
  assign q_I   = (state_q == ST_IDLE);
  assign q_L   = (state_q == ST_LEFT);
  assign q_R   = (state_q == ST_RIGHT);
  assign q_F   = (state_q == ST_FLASH);

endmodule
`default_nettype wire

// File: doc/detour_sign_n.md
DETOUR_SIGN_N -- requirements
Module: detour_sign_n

Interface
REQ-001 Parameter NUM_LAMPS, default 4: lamp count; legal range 2..16.
REQ-002 Parameter STEP_CYCLES, default 1: clocks each step is held; legal range 1..65535.
REQ-003 Derived width SW = $clog2(NUM_LAMPS+1).
REQ-004 Clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 En  input  1  enables the chase sequence.
REQ-007 L_Rbar  input  1  direction request: 1 = left, 0 = right.
REQ-008 Hazard  input  1  flash override.
REQ-009 Lamps  output  NUM_LAMPS  lamp drive; bit 0 is the leftmost lamp.
REQ-010 Step  output  SW  number of lamps lit in the current chase step (0..NUM_LAMPS).
REQ-011 q_I, q_L, q_R, q_F  output  1 each  one-hot state flags for IDLE, LEFT, RIGHT and FLASH.
REQ-012 Done  output  1  one-cycle pulse marking sequence completion.
REQ-013 All outputs SHALL be registered, with no combinational path from any input.

Function
REQ-014 States: IDLE, LEFT, RIGHT, FLASH. Exactly one q_* flag SHALL be high at all times.
REQ-015 A dwell counter (0..STEP_CYCLES-1) SHALL define the step boundary, which occurs when the counter equals STEP_CYCLES-1.
REQ-016 IDLE, En=0: Lamps=0, Step=0, and the dwell counter is held at 0.
REQ-017 IDLE, En=1: the dwell counter runs; at the boundary, sample L_Rbar and enter LEFT (1) or RIGHT (0) with Step=1.
REQ-018 RIGHT: Lamps[k] = 1 for k < Step (fills left to right).
REQ-019 LEFT: Lamps[k] = 1 for k >= NUM_LAMPS-Step (fills right to left).
REQ-020 In LEFT or RIGHT, each boundary SHALL increment Step; at the boundary with Step=NUM_LAMPS, go to IDLE, set Lamps=0 and Step=0, and pulse Done for one cycle.
REQ-021 One full cycle SHALL last (NUM_LAMPS+1)*STEP_CYCLES clocks.
REQ-022 L_Rbar changes during LEFT or RIGHT SHALL be ignored until the next IDLE sampling point.
REQ-023 En deasserted mid-sequence: the sequence SHALL finish to full and return to IDLE, then remain in IDLE.
REQ-024 Hazard=1 at any edge SHALL enter FLASH at that edge from any state, set Lamps all-ones, reset the dwell counter to 0, set Step=0, and suppress Done; Hazard SHALL have priority over En.
REQ-025 FLASH: Lamps SHALL invert at every boundary.
REQ-026 Hazard=0 in FLASH: enter IDLE at the next edge with Lamps=0 and the dwell counter at 0.
REQ-027 Step increments SHALL be SW bits wide and never exceed NUM_LAMPS; no wrap-around is permitted.

Reset
REQ-028 reset=1 SHALL immediately force IDLE, independent of Clk: q_I=1, other flags 0, Lamps=0, Step=0, Done=0, dwell counter 0.
REQ-029 Reset mid-sequence or mid-flash SHALL abort with no Done pulse.
REQ-030 After reset release, the first transition SHALL occur at the first rising edge with reset=0.

Verification (NUM_LAMPS=4, STEP_CYCLES=1 unless stated)
REQ-031 Release reset, En=1, L_Rbar=0 -> Lamps per edge 0001, 0011, 0111, 1111, 0000 with Done=1, then 0001; q_R high during the chase.
REQ-032 En=1, L_Rbar=1 -> Lamps per edge 1000, 1100, 1110, 1111, 0000; q_L high; toggling L_Rbar mid-chase has no effect.
REQ-033 STEP_CYCLES=3, right chase -> each Lamps value holds exactly 3 clocks; Done pulses once per 15 clocks, each pulse one cycle wide.
REQ-034 Hazard=1 at Step=2 -> next edge q_F=1, Lamps=1111; alternates 0000/1111 each boundary; Hazard=0 -> IDLE, Lamps=0000, no Done pulse.
REQ-035 Assert reset asynchronously between edges at Step=3 -> outputs reach reset values before the next edge; no Done pulse.
REQ-036 En=0 at Step=2 -> chase completes to 1111, Done pulses, then the block stays in IDLE with Lamps=0000.
